// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, redirect priority, stall/flush, and halts when the PC leaves the program.
// Optional FETCH_PERF_COUNTERS_EN adds saturating fetch_count/bubble_count outputs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0040_0000,
  parameter logic [31:0] TEXT_BASE    = 32'h0040_0000,
  parameter int          MEMORY_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  input  logic [31:0] rom_instruction,
  output logic [31:0] rom_address,
  output logic [31:0] pc,
  output logic [31:0] ifid_instruction,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        halted
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  localparam logic [31:0] HALT_BOUND = TEXT_BASE + 32'(4 * MEMORY_DEPTH);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_pc4_nxt;
  logic        w_valid_nxt;
  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_cand;
  logic        w_out_of_range;
  logic        w_fetch_inc;
  logic        w_bubble_inc;

  assign w_redirect  = jump_reg | jump | branch_taken;
  assign w_pc_plus4  = r_pc + 32'd4;

  always_comb begin
    w_target = branch_target;
    if (jump_reg)  w_target = jr_target;
    else if (jump) w_target = {r_pc4[31:28], jump_index, 2'b00};
    w_target = w_target & ~32'h3;
  end

  assign w_pc_cand      = w_redirect ? w_target : (stall ? r_pc : w_pc_plus4);
  assign w_out_of_range = (w_pc_cand < TEXT_BASE) || (w_pc_cand >= HALT_BOUND);

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_instr_nxt  = r_instr;
    w_pc4_nxt    = r_pc4;
    w_valid_nxt  = r_valid;
    w_fetch_inc  = 1'b0;
    w_bubble_inc = 1'b0;
    case (r_state)
      ST_RUN: begin
        // A stalled cycle counts once, whether or not it also takes a bubble.
        w_bubble_inc = stall;
        if (w_out_of_range && !stall) begin
          w_state_nxt  = ST_HALT;
          w_instr_nxt  = 32'h0;
          w_valid_nxt  = 1'b0;
          w_bubble_inc = 1'b1;
        end else begin
          w_pc_nxt = w_pc_cand;
          if (flush || w_redirect) begin
            w_instr_nxt  = 32'h0;
            w_valid_nxt  = 1'b0;
            w_bubble_inc = 1'b1;
          end else if (!stall) begin
            w_instr_nxt = rom_instruction;
            w_pc4_nxt   = w_pc_plus4;
            w_valid_nxt = 1'b1;
            w_fetch_inc = 1'b1;
          end
        end
      end
      ST_HALT: w_valid_nxt = 1'b0;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_pc4   <= 32'h0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_pc4   <= w_pc4_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign pc               = r_pc;
  assign rom_address      = r_pc - TEXT_BASE;
  assign ifid_instruction = r_instr;
  assign ifid_pc_plus4    = r_pc4;
  assign ifid_valid       = r_valid;
  assign halted           = (r_state == ST_HALT);

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_bubble_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count  <= 32'h0;
      r_bubble_count <= 32'h0;
    end else begin
      if (w_fetch_inc && (r_fetch_count != 32'hFFFF_FFFF))
        r_fetch_count <= r_fetch_count + 32'd1;
      if (w_bubble_inc && (r_bubble_count != 32'hFFFF_FFFF))
        r_bubble_count <= r_bubble_count + 32'd1;
    end
  end

  assign fetch_count  = r_fetch_count;
  assign bubble_count = r_bubble_count;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_fetch_inc ^ w_bubble_inc;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus randomized traffic against a behavioural model.
module tb_fetch_unit;
  localparam logic [31:0] TB_BASE  = 32'h0040_0000;
  localparam int          TB_DEPTH = 32;

  logic        clk;
  logic        reset, stall, flush, branch_taken, jump, jump_reg;
  logic [31:0] branch_target, jr_target;
  logic [25:0] jump_index;
  logic [31:0] rom_instruction, rom_address, pc, ifid_instruction, ifid_pc_plus4;
  logic        ifid_valid, halted;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count, bubble_count;
`endif

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index), .jump_reg(jump_reg), .jr_target(jr_target),
    .rom_instruction(rom_instruction), .rom_address(rom_address), .pc(pc),
    .ifid_instruction(ifid_instruction), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid), .halted(halted)
`ifdef FETCH_PERF_COUNTERS_EN
    , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
  );

  logic [31:0] rom_mem [0:TB_DEPTH-1];
  assign rom_instruction = (rom_address < 32'(4 * TB_DEPTH)) ? rom_mem[rom_address[6:2]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pc4, m_fetch, m_bubble;
  logic        m_valid, m_halt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    int unsigned off;
    off = a - TB_BASE;
    if (off / 4 < TB_DEPTH) return rom_mem[off / 4];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic model_step();
    logic [31:0] tgt, nxt;
    logic redir, go_halt, bub;
    if (reset) begin
      m_pc = TB_BASE; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halt = 0;
      m_fetch = 0; m_bubble = 0;
      return;
    end
    if (m_halt) return;
    redir = jump_reg || jump || branch_taken;
    if (jump_reg)  tgt = jr_target;
    else if (jump) tgt = {m_pc4[31:28], jump_index, 2'b00};
    else           tgt = branch_target;
    tgt = {tgt[31:2], 2'b00};
    nxt = redir ? tgt : (stall ? m_pc : m_pc + 4);
    go_halt = ((nxt < TB_BASE) || (nxt >= TB_BASE + 4 * TB_DEPTH)) && !stall;
    bub = 1'b0;
    if (go_halt) begin
      m_halt = 1; m_instr = 0; m_valid = 0; bub = 1;
    end else if (flush || redir) begin
      m_pc = nxt; m_instr = 0; m_valid = 0; bub = 1;
    end else if (!stall) begin
      m_instr = rom_word(m_pc); m_pc4 = m_pc + 4; m_valid = 1; m_pc = nxt;
      m_fetch = sat_inc(m_fetch);
    end
    if (bub || stall) m_bubble = sat_inc(m_bubble);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("rom_address", rom_address, m_pc - TB_BASE);
      check("ifid_instruction", ifid_instruction, m_instr);
      check("ifid_pc_plus4", ifid_pc_plus4, m_pc4);
      check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
      check("halted", {31'd0, halted}, {31'd0, m_halt});
`ifdef FETCH_PERF_COUNTERS_EN
      check("fetch_count", fetch_count, m_fetch);
      check("bubble_count", bubble_count, m_bubble);
`endif
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; branch_taken = 0; jump = 0; jump_reg = 0;
    branch_target = 0; jr_target = 0; jump_index = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rnd_tgt();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return TB_BASE - $urandom_range(1, 16);
    if (sel == 1) return TB_BASE + 4 * TB_DEPTH + $urandom_range(0, 16);
    return TB_BASE + $urandom_range(0, 4 * TB_DEPTH - 1);
  endfunction

  logic [31:0] h_instr, h_pc4;

  initial begin
    for (int i = 0; i < TB_DEPTH; i++) rom_mem[i] = $urandom;
    rom_mem[0] = 32'h2008_0005;
    idle_inputs();
    do_reset();
    chk_en = 1'b1;

    // Reset values and free-running fetch
    check("rst_pc", pc, 32'h0040_0000);
    check("rst_rom_address", rom_address, 32'h0);
    check("rst_ifid_instruction", ifid_instruction, 32'h0);
    check("rst_ifid_pc_plus4", ifid_pc_plus4, 32'h0);
    check("rst_ifid_valid", {31'd0, ifid_valid}, 32'h0);
    check("rst_halted", {31'd0, halted}, 32'h0);
    cycle();
    check("c1_instr", ifid_instruction, 32'h2008_0005);
    check("c1_pc_plus4", ifid_pc_plus4, 32'h0040_0004);
    check("c1_valid", {31'd0, ifid_valid}, 32'h1);
    check("c1_rom_address", rom_address, 32'h4);
    cycle();
    check("c2_rom_address", rom_address, 32'h8);
    cycle();
    check("c3_rom_address", rom_address, 32'hC);
    cycle();
    check("c4_pc", pc, 32'h0040_0010);

    // Branch overrides stall, squashes one slot
    do_reset();
    cycle(); cycle();
    check("br_pre_pc", pc, 32'h0040_0008);
    branch_taken = 1; branch_target = 32'h0040_0014; stall = 1;
    cycle();
    idle_inputs();
    check("br_pc", pc, 32'h0040_0014);
    check("br_bubble_valid", {31'd0, ifid_valid}, 32'h0);
    check("br_bubble_instr", ifid_instruction, 32'h0);
    cycle();
    check("br_after_instr", ifid_instruction, rom_mem[5]);
    check("br_after_pc4", ifid_pc_plus4, 32'h0040_0018);
    check("br_after_valid", {31'd0, ifid_valid}, 32'h1);

    // Redirect priority, with a misaligned jr target
    do_reset();
    jump_reg = 1; jr_target = 32'h0040_0023; jump = 1; jump_index = 26'h010_0004;
    branch_taken = 1; branch_target = 32'h0040_0030;
    cycle();
    idle_inputs();
    check("prio_pc", pc, 32'h0040_0020);

    // Stall for 3 cycles
    do_reset();
    cycle(); cycle(); cycle();
    check("st_pre_pc", pc, 32'h0040_000C);
    check("st_pre_instr", ifid_instruction, rom_mem[2]);
    h_instr = ifid_instruction; h_pc4 = ifid_pc_plus4;
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("st_hold_pc", pc, 32'h0040_000C);
      check("st_hold_instr", ifid_instruction, h_instr);
      check("st_hold_pc4", ifid_pc_plus4, h_pc4);
    end
    stall = 0;
    cycle();
    check("st_release_pc", pc, 32'h0040_0010);

    // Run off the end of the program
    do_reset();
    for (int k = 0; k < 31; k++) cycle();
    check("end_pc", pc, 32'h0040_007C);
    cycle();
    check("halt_flag", {31'd0, halted}, 32'h1);
    check("halt_pc", pc, 32'h0040_007C);
    check("halt_valid", {31'd0, ifid_valid}, 32'h0);
    jump = 1; jump_index = 26'h010_0002;
    cycle();
    idle_inputs();
    check("halt_ignore_jump_pc", pc, 32'h0040_007C);
    check("halt_ignore_jump_flag", {31'd0, halted}, 32'h1);
    do_reset();
    check("halt_reset_pc", pc, 32'h0040_0000);
    check("halt_reset_flag", {31'd0, halted}, 32'h0);

`ifdef FETCH_PERF_COUNTERS_EN
    // 10 cycles: 1 redirect, 2 stall cycles
    do_reset();
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      if (c == 3) begin branch_taken = 1; branch_target = 32'h0040_0040; end
      if (c == 4 || c == 5) stall = 1;
      cycle();
    end
    idle_inputs();
    check("perf_fetch", fetch_count, 32'd7);
    check("perf_bubble", bubble_count, 32'd3);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 39) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      jump          = ($urandom_range(0, 15) == 0);
      jump_reg      = ($urandom_range(0, 15) == 0);
      branch_target = rnd_tgt();
      jr_target     = rnd_tgt();
      jump_index    = 26'((TB_BASE >> 2) + $urandom_range(0, TB_DEPTH + 2));
      cycle();
    end
    reset = 0;
    idle_inputs();
    cycle();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
